// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: issues one req/ack bus transaction per load or store,
// stalls the core until it completes, and returns extended load data.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic [1:0]  MemWrite,
    input  logic [2:0]  MemRead,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        bus_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt;
    logic [1:0]  r_size;
    logic        r_sign;
    logic [1:0]  r_lo;
    logic        r_bus_req, r_bus_we, r_done, r_misalign, r_bus_fault;
    logic [31:0] r_bus_addr, r_bus_wdata, r_rdata;
    logic [3:0]  r_bus_be;

    logic        w_store, w_acc, w_sign, w_misalign;
    logic [1:0]  w_size;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_latch, w_cnt_inc, w_mis_nxt, w_flt_nxt, w_ack_hit;

    // Pick the addressed byte/half out of the bus word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic        sign,
                                                 input logic [1:0]  lo);
        logic [7:0]  v_b;
        logic [15:0] v_h;
        v_b = word[{lo, 3'b000} +: 8];
        v_h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    load_extract = sign ? {{24{v_b[7]}}, v_b} : {24'b0, v_b};
            SZ_H:    load_extract = sign ? {{16{v_h[15]}}, v_h} : {16'b0, v_h};
            default: load_extract = word;
        endcase
    endfunction

    assign w_store = (MemWrite != 2'b00);
    assign w_acc   = w_store | load_en;

    always_comb begin
        w_size = SZ_W;
        w_sign = 1'b0;
        if (w_store) begin
            case (MemWrite)
                2'b01:   w_size = SZ_B;
                2'b10:   w_size = SZ_H;
                default: w_size = SZ_W;
            endcase
        end else begin
            case (MemRead)
                3'b001:  begin w_size = SZ_B; w_sign = 1'b1; end
                3'b010:  begin w_size = SZ_H; w_sign = 1'b1; end
                3'b011:  w_size = SZ_B;
                3'b100:  w_size = SZ_H;
                default: w_size = SZ_W;
            endcase
        end
    end

    assign w_misalign = ((w_size == SZ_H) && addr[0]) ||
                        ((w_size == SZ_W) && (addr[1:0] != 2'b00));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata;
        case (w_size)
            SZ_B: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            SZ_H: begin
                w_be    = 4'b0011 << {addr[1], 1'b0};
                w_wdata = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_cnt_inc   = 1'b0;
        w_mis_nxt   = 1'b0;
        w_flt_nxt   = 1'b0;
        w_ack_hit   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    if (w_misalign) begin
                        w_state_nxt = S_DONE;
                        w_mis_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_latch     = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (bus_ack) begin
                    w_state_nxt = S_DONE;
                    w_ack_hit   = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_DONE;
                    w_flt_nxt   = 1'b1;
                end else begin
                    w_cnt_inc   = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_size      <= SZ_W;
            r_sign      <= 1'b0;
            r_lo        <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
            r_done      <= 1'b0;
            r_misalign  <= 1'b0;
            r_bus_fault <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_bus_req   <= (w_state_nxt == S_WAIT);
            r_done      <= (w_state_nxt == S_DONE);
            r_misalign  <= w_mis_nxt;
            r_bus_fault <= w_flt_nxt;
            r_rdata     <= (w_ack_hit && !r_bus_we) ?
                           load_extract(bus_rdata, r_size, r_sign, r_lo) : '0;
            if (w_latch) begin
                r_bus_addr  <= {addr[31:2], 2'b00};
                r_bus_be    <= w_be;
                r_bus_we    <= w_store;
                r_bus_wdata <= w_wdata;
                r_size      <= w_size;
                r_sign      <= w_sign;
                r_lo        <= addr[1:0];
                r_cnt       <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign stall     = ((r_state == S_IDLE) && w_acc) || (r_state == S_WAIT);
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign misalign  = r_misalign;
    assign bus_fault = r_bus_fault;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_be    = r_bus_be;
    assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads, misalignment, timeout,
// priority, back-to-back accesses and reset during a pending bus request.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        load_en;
    logic [1:0]  MemWrite;
    logic [2:0]  MemRead;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;
    logic        bus_fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    int          res_done_cyc, res_req, res_stall;
    logic [31:0] res_rdata, res_baddr, res_bwd;
    logic [3:0]  res_be;
    logic        res_we, res_mis, res_flt;

    load_store_unit #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .MemWrite(MemWrite),
        .MemRead(MemRead), .addr(addr), .wdata(wdata), .stall(stall),
        .done(done), .rdata(rdata), .misalign(misalign), .bus_fault(bus_fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one access starting in the next cycle (cycle 0) and follow it to done.
    // ack_after = number of WAIT cycles before ack; negative means never ack.
    task automatic drive_access(input logic le, input logic [1:0] mw, input logic [2:0] mr,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input int ack_after);
        step();
        load_en = le; MemWrite = mw; MemRead = mr; addr = a; wdata = wd; bus_ack = 1'b0;
        res_done_cyc = -1; res_req = 0; res_stall = 0;
        res_rdata = '0; res_baddr = '0; res_bwd = '0; res_be = '0;
        res_we = 1'b0; res_mis = 1'b0; res_flt = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (stall) res_stall++;
            if (done) begin
                res_done_cyc = cyc;
                res_rdata = rdata; res_mis = misalign; res_flt = bus_fault;
                if (bus_req) res_req++;
                load_en = 1'b0; MemWrite = 2'b00;
                break;
            end
            if (bus_req) begin
                res_req++;
                res_be = bus_be; res_baddr = bus_addr; res_bwd = bus_wdata; res_we = bus_we;
            end
            if (bus_req && ack_after >= 0 && (res_req - 1) == ack_after) begin
                bus_ack = 1'b1; bus_rdata = rd;
            end else begin
                bus_ack = 1'b0; bus_rdata = 32'hDEADBEEF;
            end
            step();
        end
        bus_ack = 1'b0;
        checks++;
        if (res_done_cyc < 0) begin
            errors++;
            $display("FAIL access_done_timeout: got no done within 40 cycles, expected done");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if ({bus_req, bus_we, done, misalign, bus_fault} !== 5'b0) begin errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {bus_req, bus_we, done, misalign, bus_fault}); end
        checks++; if (bus_addr !== 32'h0 || bus_be !== 4'h0) begin errors++;
            $display("FAIL reset_addr_be: got %h/%b expected 00000000/0000", bus_addr, bus_be); end
        checks++; if (bus_wdata !== 32'h0 || rdata !== 32'h0) begin errors++;
            $display("FAIL reset_data: got %h/%h expected 0/0", bus_wdata, rdata); end
        checks++; if (stall !== 1'b0) begin errors++;
            $display("FAIL reset_stall: got %b expected 0", stall); end
        rst_n = 1'b1;
    endtask

    task automatic test_store();
        drive_access(1'b0, 2'b01, 3'b000, 32'h1003, 32'h000000A5, 32'h0, 2);
        checks++; if (res_done_cyc !== 4) begin errors++;
            $display("FAIL sb_done_cycle: got %0d expected 4", res_done_cyc); end
        checks++; if (res_stall !== 4) begin errors++;
            $display("FAIL sb_stall_cycles: got %0d expected 4", res_stall); end
        checks++; if (res_req !== 3) begin errors++;
            $display("FAIL sb_req_cycles: got %0d expected 3", res_req); end
        checks++; if ({res_we, res_be, res_baddr, res_bwd} !== {1'b1, 4'b1000, 32'h1000, 32'hA5A5A5A5}) begin errors++;
            $display("FAIL sb_bus: got we=%b be=%b a=%h d=%h expected 1 1000 00001000 a5a5a5a5", res_we, res_be, res_baddr, res_bwd); end
        checks++; if ({res_rdata, res_mis, res_flt} !== {32'h0, 2'b00}) begin errors++;
            $display("FAIL sb_result: got rdata=%h mis=%b flt=%b expected 0 0 0", res_rdata, res_mis, res_flt); end

        drive_access(1'b0, 2'b10, 3'b000, 32'h1002, 32'h1234BEEF, 32'h0, 0);
        checks++; if ({res_done_cyc == 2, res_be, res_bwd} !== {1'b1, 4'b1100, 32'hBEEFBEEF}) begin errors++;
            $display("FAIL sh_bus: got cyc=%0d be=%b d=%h expected 2 1100 beefbeef", res_done_cyc, res_be, res_bwd); end

        drive_access(1'b0, 2'b11, 3'b000, 32'h1004, 32'hCAFEF00D, 32'h0, 1);
        checks++; if ({res_done_cyc == 3, res_be, res_baddr, res_bwd} !== {1'b1, 4'b1111, 32'h1004, 32'hCAFEF00D}) begin errors++;
            $display("FAIL sw_bus: got cyc=%0d be=%b a=%h d=%h expected 3 1111 00001004 cafef00d", res_done_cyc, res_be, res_baddr, res_bwd); end
    endtask

    task automatic test_load_byte();
        drive_access(1'b1, 2'b00, 3'b001, 32'h2001, 32'h0, 32'h0000F000, 0);
        checks++; if (res_rdata !== 32'hFFFFFFF0) begin errors++;
            $display("FAIL lb_rdata: got %h expected fffffff0", res_rdata); end
        checks++; if ({res_done_cyc == 2, res_we, res_be, res_baddr} !== {1'b1, 1'b0, 4'b0010, 32'h2000}) begin errors++;
            $display("FAIL lb_bus: got cyc=%0d we=%b be=%b a=%h expected 2 0 0010 00002000", res_done_cyc, res_we, res_be, res_baddr); end
        drive_access(1'b1, 2'b00, 3'b011, 32'h2001, 32'h0, 32'h0000F000, 0);
        checks++; if (res_rdata !== 32'h000000F0) begin errors++;
            $display("FAIL lbu_rdata: got %h expected 000000f0", res_rdata); end
    endtask

    task automatic test_load_half_word();
        drive_access(1'b1, 2'b00, 3'b010, 32'h2002, 32'h0, 32'h80010000, 0);
        checks++; if (res_rdata !== 32'hFFFF8001 || res_be !== 4'b1100) begin errors++;
            $display("FAIL lh_rdata: got %h be=%b expected ffff8001 1100", res_rdata, res_be); end
        drive_access(1'b1, 2'b00, 3'b100, 32'h2002, 32'h0, 32'h80010000, 0);
        checks++; if (res_rdata !== 32'h00008001) begin errors++;
            $display("FAIL lhu_rdata: got %h expected 00008001", res_rdata); end
        drive_access(1'b1, 2'b00, 3'b000, 32'h2000, 32'h0, 32'h80010000, 0);
        checks++; if (res_rdata !== 32'h80010000 || res_be !== 4'b1111) begin errors++;
            $display("FAIL lw_rdata: got %h be=%b expected 80010000 1111", res_rdata, res_be); end
        drive_access(1'b1, 2'b00, 3'b101, 32'h2000, 32'h0, 32'h80010000, 0);
        checks++; if (res_rdata !== 32'h80010000) begin errors++;
            $display("FAIL lw_alias_rdata: got %h expected 80010000", res_rdata); end
    endtask

    task automatic test_misalign();
        drive_access(1'b0, 2'b10, 3'b000, 32'h3001, 32'hFFFF, 32'h0, 0);
        checks++; if ({res_done_cyc == 1, res_req, res_mis, res_flt, res_rdata} !== {1'b1, 32'd0, 1'b1, 1'b0, 32'h0}) begin errors++;
            $display("FAIL sh_misalign: got cyc=%0d req=%0d mis=%b flt=%b rdata=%h expected 1 0 1 0 0", res_done_cyc, res_req, res_mis, res_flt, res_rdata); end
        drive_access(1'b1, 2'b00, 3'b000, 32'h3002, 32'h0, 32'h12345678, 0);
        checks++; if ({res_done_cyc == 1, res_req, res_mis, res_rdata} !== {1'b1, 32'd0, 1'b1, 32'h0}) begin errors++;
            $display("FAIL lw_misalign: got cyc=%0d req=%0d mis=%b rdata=%h expected 1 0 1 0", res_done_cyc, res_req, res_mis, res_rdata); end
        checks++; if (res_stall !== 1) begin errors++;
            $display("FAIL misalign_stall: got %0d expected 1", res_stall); end
    endtask

    task automatic test_timeout();
        drive_access(1'b1, 2'b00, 3'b000, 32'h4000, 32'h0, 32'h0, -1);
        checks++; if (res_req !== 4) begin errors++;
            $display("FAIL timeout_req_cycles: got %0d expected 4", res_req); end
        checks++; if ({res_done_cyc == 5, res_flt, res_mis, res_rdata} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin errors++;
            $display("FAIL timeout_result: got cyc=%0d flt=%b mis=%b rdata=%h expected 5 1 0 0", res_done_cyc, res_flt, res_mis, res_rdata); end
    endtask

    task automatic test_priority();
        drive_access(1'b1, 2'b11, 3'b001, 32'h5000, 32'h12345678, 32'hFFFFFFFF, 0);
        checks++; if ({res_we, res_be, res_bwd, res_rdata} !== {1'b1, 4'b1111, 32'h12345678, 32'h0}) begin errors++;
            $display("FAIL store_priority: got we=%b be=%b d=%h rdata=%h expected 1 1111 12345678 0", res_we, res_be, res_bwd, res_rdata); end
    endtask

    task automatic test_back_to_back();
        drive_access(1'b1, 2'b00, 3'b011, 32'h2003, 32'h0, 32'hAB000000, 0);
        checks++; if (res_rdata !== 32'h000000AB || res_done_cyc !== 2) begin errors++;
            $display("FAIL b2b_first: got rdata=%h cyc=%0d expected 000000ab 2", res_rdata, res_done_cyc); end
        drive_access(1'b1, 2'b00, 3'b001, 32'h2000, 32'h0, 32'h00000080, 0);
        checks++; if (res_rdata !== 32'hFFFFFF80 || res_done_cyc !== 2) begin errors++;
            $display("FAIL b2b_second: got rdata=%h cyc=%0d expected ffffff80 2", res_rdata, res_done_cyc); end
    endtask

    task automatic test_reset_mid_wait();
        step();
        load_en = 1'b1; MemWrite = 2'b00; MemRead = 3'b000; addr = 32'h6000; bus_ack = 1'b0;
        step();
        checks++; if (bus_req !== 1'b1) begin errors++;
            $display("FAIL rstwait_req_before: got %b expected 1", bus_req); end
        step();
        rst_n = 1'b0; load_en = 1'b0;
        step();
        rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h11111111;
        checks++; if ({bus_req, done, stall} !== 3'b000) begin errors++;
            $display("FAIL rstwait_after: got req/done/stall=%b expected 000", {bus_req, done, stall}); end
        step();
        checks++; if ({bus_req, done} !== 2'b00) begin errors++;
            $display("FAIL rstwait_late_ack: got req/done=%b expected 00", {bus_req, done}); end
        bus_ack = 1'b0;
        step();
        checks++; if (done !== 1'b0 || rdata !== 32'h0) begin errors++;
            $display("FAIL rstwait_no_done: got done=%b rdata=%h expected 0 0", done, rdata); end
    endtask

    initial begin
        rst_n = 1'b0; load_en = 1'b0; MemWrite = 2'b00; MemRead = 3'b000;
        addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
        test_reset();
        test_store();
        test_load_byte();
        test_load_half_word();
        test_misalign();
        test_timeout();
        test_priority();
        test_back_to_back();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the control unit / ALU and the data-memory bus. It consumes the decoded store size (`MemWrite`), load type (`MemRead`) and a load flag, together with the ALU-computed address and the rs2 data. It drives a req/ack word-addressed memory bus with byte enables, stalls the core until the access completes, and returns aligned, sign- or zero-extended load data for write-back. It also detects misaligned accesses and bus timeouts.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 16: maximum WAIT cycles without `bus_ack` before the access faults (legal range 1–255).

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — synchronous, active-low reset.
- `load_en`  in  1  — current instruction is a load (top drives `ResultSrc == 2'b01`).
- `MemWrite`  in  2  — 00 none, 01 sb, 10 sh, 11 sw.
- `MemRead`  in  3  — load type, valid when `load_en`=1: 000 lw, 001 lb, 010 lh, 011 lbu, 100 lhu; 101–111 treated as lw.
- `addr`  in  32  — byte address (ALU result).
- `wdata`  in  32  — store data (rs2).
- `stall`  out  1  — core must hold PC and all inputs stable while high.
- `done`  out  1  — one-cycle pulse; access finished (success or fault).
- `rdata`  out  32  — extended load data; valid only while `done`=1.
- `misalign`  out  1  — qualifies `done`: access was misaligned and was not issued.
- `bus_fault`  out  1  — qualifies `done`: bus timeout.
- `bus_req`  out  1  — bus request, registered.
- `bus_we`  out  1  — 1 store, 0 load.
- `bus_addr`  out  32  — `{addr[31:2],2'b00}`.
- `bus_be`  out  4  — byte enables.
- `bus_wdata`  out  32  — lane-replicated store data.
- `bus_ack`  in  1  — completes the request in the cycle it is sampled high.
- `bus_rdata`  in  32  — read word; valid when `bus_ack`=1.

## Operation
- Access request (`acc`): `MemWrite != 00` or `load_en`. If both are asserted, the store wins and the load is ignored.
- Size: byte (sb, lb, lbu), half (sh, lh, lhu), or word.
- Misaligned: a half access with `addr[0]`=1, or a word access with `addr[1:0] != 00`.
- FSM states: IDLE, WAIT, DONE.
  - IDLE + aligned `acc`: latch `bus_addr`, `bus_be`, `bus_we`, `bus_wdata`, size, sign and `addr[1:0]`; clear the timeout counter; go to WAIT.
  - IDLE + misaligned `acc`: no bus request; go to DONE with `misalign`=1.
  - IDLE + no `acc`: stay in IDLE.
  - WAIT + `bus_ack`: capture extended load data; go to DONE.
  - WAIT + no ack + counter = `TIMEOUT_CYC-1`: go to DONE with `bus_fault`=1. Otherwise the counter increments.
  - DONE: always go to IDLE. Request inputs are ignored in this state.
- `bus_req` = 1 exactly while in WAIT. `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` hold their latched values in WAIT.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << {addr[1],1'b0}`
  - word: `4'b1111`
  - Loads drive the same byte enables, with `bus_we`=0.
- Store data lanes:
  - sb: `{4{wdata[7:0]}}`
  - sh: `{2{wdata[15:0]}}`
  - sw: `wdata`
- Load extraction:
  - lb/lbu: byte at lane `addr[1:0]`, sign- or zero-extended to 32 bits.
  - lh/lhu: half at lane `addr[1]`, sign- or zero-extended.
  - lw: the full word.
- `rdata` = 0 on stores, misaligned accesses and faults.
- A misaligned store never asserts `bus_req`, so memory is not written.

## Timing
- `stall` (combinational) = (IDLE & `acc`) | WAIT. `stall` = 0 in DONE, so the core retires the instruction at the end of the DONE cycle (write-back of `rdata` happens at that edge).
- Aligned access: request seen in cycle 0 (IDLE), `bus_req` high from cycle 1, ack in cycle 1+N, `done` in cycle 2+N.
  - Minimum 3 cycles per access (ack in the first WAIT cycle).
  - A back-to-back access is seen in IDLE on the cycle after DONE.
- Misaligned: `acc` in cycle 0, `done` + `misalign` in cycle 1, no bus activity.
- Timeout: `bus_req` high for exactly `TIMEOUT_CYC` cycles, then `done` + `bus_fault`, with `bus_req` low in DONE.
- `bus_ack` outside WAIT is ignored. `bus_rdata` is sampled only in the ack cycle.
- Registered output `done` is a pulse driven to 0 on any cycle not in DONE; `misalign` and `bus_fault` are 0 whenever `done` = 0.
- Reset values:
  - state = IDLE
  - `bus_req`, `bus_we`, `done`, `misalign`, `bus_fault` = 0
  - `bus_addr`, `bus_be`, `bus_wdata`, `rdata` = 0
  - counter = 0
- Reset mid-WAIT: `bus_req` = 0 from the next cycle, no `done` is generated, and any late `bus_ack` is ignored.

## Test plan
- sb: `addr`=0x1003, `wdata`=0xA5, ack after 2 cycles → `bus_addr`=0x1000, `be`=1000, `bus_wdata`=0xA5A5A5A5, `done` in cycle 4, `stall` high cycles 0–3.
- lb / lbu: `addr`=0x2001, `bus_rdata`=0x0000F000 with immediate ack → lb `rdata`=0xFFFFFFF0, lbu `rdata`=0x000000F0, `done` in cycle 2.
- lh / lhu: `addr`=0x2002, `bus_rdata`=0x80010000 → `be`=1100, lh `rdata`=0xFFFF8001, lhu `rdata`=0x00008001; lw at 0x2000 → `rdata`=0x80010000.
- Misaligned: sh at 0x3001 and lw at 0x3002 → no `bus_req`, `done` + `misalign` in cycle 1, `rdata`=0.
- Timeout: lw with `bus_ack` held 0, `TIMEOUT_CYC`=4 → `bus_req` high for exactly 4 cycles, then `done` + `bus_fault`, `rdata`=0.
- Reset and priority:
  - `rst_n`=0 during WAIT → next cycle IDLE, `bus_req`=0, no `done`; a late ack is ignored.
  - `load_en`=1 together with `MemWrite`=11 → a store is issued (`bus_we`=1).
